// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared types and constants for the VGA colour control path.
//                Provides the channel enumeration, the full-intensity colour
//                constant and a channel-advance helper.
//  Revision    : 1.0  initial release
// ============================================================================
package vga_pkg;

    typedef enum logic [1:0] {
        CH_RED   = 2'd0,
        CH_GREEN = 2'd1,
        CH_BLUE  = 2'd2
    } channel_t;

    localparam logic [1:0] COLOR_FULL = 2'b11;

    // RED -> GREEN -> BLUE -> RED; the unused encoding also returns to RED.
    function automatic channel_t nextChannel(input channel_t ch);
        channel_t w_next;
        case (ch)
            CH_RED:   w_next = CH_GREEN;
            CH_GREEN: w_next = CH_BLUE;
            default:  w_next = CH_RED;
        endcase
        return w_next;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : button_debouncer
//  Description : Two-flop synchronizer, counting debouncer and press-pulse
//                generator for one active-low pushbutton.
//  Ports       : clk        - system clock
//                rst_n      - asynchronous active-low reset
//                i_buttonN  - raw button, active-low, asynchronous
//                o_press    - one-cycle pulse after a debounced press
//  Revision    : 1.0  initial release
// ============================================================================
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_buttonN,
    output logic o_press
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_synced;
    logic               r_stable;
    logic               r_stableD;
    logic [c_CNT_W-1:0] r_count;
    logic [1:0]         r_fill;
    logic               r_armed;
    logic               r_press;

    // r_fill/r_armed: pulses are suppressed until the button has been seen
    // released after reset, so a button held through reset never fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_synced  <= 1'b1;
            r_stable  <= 1'b1;
            r_stableD <= 1'b1;
            r_count   <= '0;
            r_fill    <= 2'd0;
            r_armed   <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_sync1   <= i_buttonN;
            r_synced  <= r_sync1;
            r_stableD <= r_stable;
            r_press   <= r_armed & r_stableD & ~r_stable;

            // Two edges are needed before r_synced holds a real sample.
            if (r_fill != 2'd2) begin
                r_fill <= r_fill + 2'd1;
            end
            if (r_fill == 2'd2 && r_synced && r_stable) begin
                r_armed <= 1'b1;
            end

            if (r_synced == r_stable) begin
                r_count <= '0;
            end else if (r_count == c_CNT_MAX) begin
                r_stable <= r_synced;
                r_count  <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/vga_color_selector.sv
`default_nettype none
// ============================================================================
//  Module      : vga_color_selector
//  Description : Turns two raw pushbuttons into per-channel 2-bit intensity
//                controls. Edits go to pending registers and are committed on
//                the falling edge of vsync so colours never change mid-frame.
//  Ports       : clock50Mhz      - system clock
//                reset_n         - asynchronous active-low reset
//                incButton_n     - raw increment button, active-low
//                selButton_n     - raw channel-select button, active-low
//                vsync           - driver vsync, active-low, same domain
//                redControl      - committed red intensity
//                greenControl    - committed green intensity
//                blueControl     - committed blue intensity
//                selectedChannel - channel being edited (0 R, 1 G, 2 B)
//  Revision    : 1.0  initial release
// ============================================================================
module vga_color_selector
    import vga_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clock50Mhz,
    input  logic       reset_n,
    input  logic       incButton_n,
    input  logic       selButton_n,
    input  logic       vsync,
    output logic [1:0] redControl,
    output logic [1:0] greenControl,
    output logic [1:0] blueControl,
    output logic [1:0] selectedChannel
);

    logic       w_incPress;
    logic       w_selPress;
    logic       w_commit;

    channel_t   r_channel;
    logic [1:0] r_pendR;
    logic [1:0] r_pendG;
    logic [1:0] r_pendB;
    logic       r_vsyncD;
    logic [1:0] r_red;
    logic [1:0] r_green;
    logic [1:0] r_blue;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_incDebouncer (
        .clk      (clock50Mhz),
        .rst_n    (reset_n),
        .i_buttonN(incButton_n),
        .o_press  (w_incPress)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_selDebouncer (
        .clk      (clock50Mhz),
        .rst_n    (reset_n),
        .i_buttonN(selButton_n),
        .o_press  (w_selPress)
    );

    // vsync falling edge; the commit loads the pending values as they stood
    // before any increment landing on the same edge.
    assign w_commit = ~vsync & r_vsyncD;

    always_ff @(posedge clock50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_channel <= CH_RED;
            r_pendR   <= COLOR_FULL;
            r_pendG   <= COLOR_FULL;
            r_pendB   <= COLOR_FULL;
            r_vsyncD  <= 1'b1;
            r_red     <= COLOR_FULL;
            r_green   <= COLOR_FULL;
            r_blue    <= COLOR_FULL;
        end else begin
            r_vsyncD <= vsync;

            // Increment targets the channel selected before any advance.
            if (w_incPress) begin
                case (r_channel)
                    CH_RED:   r_pendR <= r_pendR + 2'd1;
                    CH_GREEN: r_pendG <= r_pendG + 2'd1;
                    default:  r_pendB <= r_pendB + 2'd1;
                endcase
            end

            if (w_selPress) begin
                r_channel <= nextChannel(r_channel);
            end

            if (w_commit) begin
                r_red   <= r_pendR;
                r_green <= r_pendG;
                r_blue  <= r_pendB;
            end
        end
    end

    assign redControl      = r_red;
    assign greenControl    = r_green;
    assign blueControl     = r_blue;
    assign selectedChannel = r_channel;

endmodule
`default_nettype wire
